// File: rtl/l2s_pkg.sv
// Shared constants and types for the AXI-Lite to AXI-Stream adapter.
// The FIFO entry carries the full data word plus its end-of-frame flag.
package l2s_pkg;

  // Entry width; the adapter's C_S_AXI_DATA_WIDTH must equal this.
  localparam int L2S_DATA_W = 32;

  localparam int unsigned OFF_DATA        = 'h00;
  localparam int unsigned OFF_DATA_LAST   = 'h04;
  localparam int unsigned OFF_STATUS      = 'h08;
  localparam int unsigned OFF_CTRL        = 'h0C;
  localparam int unsigned OFF_WORD_COUNT  = 'h10;
  localparam int unsigned OFF_FRAME_COUNT = 'h14;

  localparam int STATUS_FULL      = 0;
  localparam int STATUS_EMPTY     = 1;
  localparam int STATUS_LEVEL_LSB = 2;
  localparam int STATUS_OVERFLOW  = 8;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_OVF_CLR = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic                  tlast;
    logic [L2S_DATA_W-1:0] tdata;
  } l2s_entry_t;

endpackage

// File: rtl/axi_lite2stream_adapter_if.sv
// Bus bundle for the adapter: AXI4-Lite slave channels, AXI4-Stream master and FSM debug taps.
// valid/ready: a transfer happens on each rising clock edge where both are high; valid never waits on ready.
interface axi_lite2stream_adapter_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic [2:0]                      s_axi_awprot;
  logic                            s_axi_awvalid;
  logic                            s_axi_awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                            s_axi_wvalid;
  logic                            s_axi_wready;
  logic [1:0]                      s_axi_bresp;
  logic                            s_axi_bvalid;
  logic                            s_axi_bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr;
  logic [2:0]                      s_axi_arprot;
  logic                            s_axi_arvalid;
  logic                            s_axi_arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata;
  logic [1:0]                      s_axi_rresp;
  logic                            s_axi_rvalid;
  logic                            s_axi_rready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   m_axis_tdata;
  logic                            m_axis_tlast;
  logic                            m_axis_tvalid;
  logic                            m_axis_tready;
  logic [0:0]                      dbg_wr_state;
  logic [0:0]                      dbg_rd_state;

  modport slave (
    input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    input  s_axi_rready,
    input  m_axis_tready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    output m_axis_tdata, m_axis_tlast, m_axis_tvalid,
    output dbg_wr_state, dbg_rd_state
  );

  modport master (
    output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    output s_axi_rready,
    output m_axis_tready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    input  m_axis_tdata, m_axis_tlast, m_axis_tvalid,
    input  dbg_wr_state, dbg_rd_state
  );
endinterface

// File: rtl/l2s_fifo.sv
// Synchronous FIFO of l2s_entry_t; pointers carry an extra wrap bit to tell full from empty.
// The head reads as zero while the FIFO is empty.
module l2s_fifo
  import l2s_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  l2s_entry_t               push_data,
  input  logic                     pop,
  output l2s_entry_t               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  l2s_entry_t  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      // Flush discards everything, including a head popped this cycle.
      if (flush)       rd_ptr <= wr_ptr;
      else if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/axi_lite2stream_adapter.sv
// AXI4-Lite register file feeding an AXI4-Stream master through a small FIFO.
// Define L2S_COUNTERS_EN to implement the WORD_COUNT/FRAME_COUNT registers.
module axi_lite2stream_adapter
  import l2s_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = L2S_DATA_W,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH         = 4
) (
  input logic                       aclk,
  input logic                       areset,
  axi_lite2stream_adapter_if.slave  bus
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int DW    = C_S_AXI_DATA_WIDTH;

  localparam logic [0:0] WR_IDLE = 1'b0;
  localparam logic [0:0] WR_RESP = 1'b1;
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_DATA = 1'b1;

  logic [0:0]       wr_state;
  logic [0:0]       rd_state;
  logic             wr_hs;
  logic             rd_hs;
  logic [AW-1:0]    wr_off;
  logic [AW-1:0]    rd_off;
  logic             wr_ctrl;
  logic             push_req;
  logic             push_last;
  logic             flush;
  logic             pop;
  logic             tvalid;
  logic             enable;
  logic             overflow;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  l2s_entry_t       push_entry;
  l2s_entry_t       head;
  logic [1:0]       bresp_q;
  logic [DW-1:0]    rdata_q;
  logic [DW-1:0]    rd_mux;
  logic [DW-1:0]    status;
  logic [DW-1:0]    word_count;
  logic [DW-1:0]    frame_count;
  logic             unused;

  assign wr_hs     = bus.s_axi_awvalid && bus.s_axi_wvalid && (wr_state == WR_IDLE);
  assign rd_hs     = bus.s_axi_arvalid && (rd_state == RD_IDLE);
  assign wr_off    = {bus.s_axi_awaddr[AW-1:2], 2'b00};
  assign rd_off    = {bus.s_axi_araddr[AW-1:2], 2'b00};
  assign push_last = (wr_off == AW'(OFF_DATA_LAST));
  assign push_req  = wr_hs && ((wr_off == AW'(OFF_DATA)) || push_last);
  assign wr_ctrl   = wr_hs && (wr_off == AW'(OFF_CTRL)) && bus.s_axi_wstrb[0];
  assign flush     = wr_ctrl && bus.s_axi_wdata[CTRL_FLUSH];
  assign tvalid    = enable && !fifo_empty;
  assign pop       = tvalid && bus.m_axis_tready;

  assign push_entry.tlast = push_last;
  assign push_entry.tdata = bus.s_axi_wdata;

  l2s_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (aclk),
    .rst       (areset),
    .flush     (flush),
    .push      (push_req),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Full is sampled before this cycle's pop, so a push into a full FIFO is refused.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_state <= WR_IDLE;
      bresp_q  <= RESP_OKAY;
    end else begin
      case (wr_state)
        WR_IDLE: if (wr_hs) begin
          wr_state <= WR_RESP;
          bresp_q  <= (push_req && fifo_full) ? RESP_SLVERR : RESP_OKAY;
        end
        default: if (bus.s_axi_bready) wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      enable   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl) enable <= bus.s_axi_wdata[CTRL_ENABLE];
      if (push_req && fifo_full)                        overflow <= 1'b1;
      else if (wr_ctrl && bus.s_axi_wdata[CTRL_OVF_CLR]) overflow <= 1'b0;
    end
  end

`ifdef L2S_COUNTERS_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      word_count  <= '0;
      frame_count <= '0;
    end else if (pop) begin
      word_count <= word_count + 1'b1;
      if (head.tlast) frame_count <= frame_count + 1'b1;
    end
  end
`else
  assign word_count  = '0;
  assign frame_count = '0;
`endif

  always_comb begin
    status                                = '0;
    status[STATUS_FULL]                   = fifo_full;
    status[STATUS_EMPTY]                  = fifo_empty;
    status[STATUS_LEVEL_LSB +: LVL_W]     = fifo_level;
    status[STATUS_OVERFLOW]               = overflow;
  end

  always_comb begin
    rd_mux = '0;
    case (rd_off)
      AW'(OFF_STATUS):      rd_mux = status;
      AW'(OFF_CTRL):        rd_mux[CTRL_ENABLE] = enable;
      AW'(OFF_WORD_COUNT):  rd_mux = word_count;
      AW'(OFF_FRAME_COUNT): rd_mux = frame_count;
      default:              rd_mux = '0;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_state <= RD_IDLE;
      rdata_q  <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: if (rd_hs) begin
          rd_state <= RD_DATA;
          rdata_q  <= rd_mux;
        end
        default: if (bus.s_axi_rready) rd_state <= RD_IDLE;
      endcase
    end
  end

  assign bus.s_axi_awready = wr_hs;
  assign bus.s_axi_wready  = wr_hs;
  assign bus.s_axi_bvalid  = (wr_state == WR_RESP);
  assign bus.s_axi_bresp   = bresp_q;
  assign bus.s_axi_arready = rd_hs;
  assign bus.s_axi_rvalid  = (rd_state == RD_DATA);
  assign bus.s_axi_rdata   = rdata_q;
  assign bus.s_axi_rresp   = RESP_OKAY;
  assign bus.m_axis_tvalid = tvalid;
  assign bus.m_axis_tdata  = head.tdata;
  assign bus.m_axis_tlast  = head.tlast;
  assign bus.dbg_wr_state  = wr_state;
  assign bus.dbg_rd_state  = rd_state;

  assign unused = ^{bus.s_axi_awprot, bus.s_axi_arprot, bus.s_axi_awaddr[1:0],
                    bus.s_axi_araddr[1:0], bus.s_axi_wstrb[DW/8-1:1]};
endmodule

// File: doc/axi_lite2stream_adapter.md
# axi_lite2stream_adapter

Memory-mapped-to-stream bridge: the CPU writes data words through an AXI4-Lite slave register file, and the block emits them as an AXI4-Stream master towards the multiplier. It is the transmit-side counterpart of the stream-to-lite interface. A small FIFO decouples CPU writes from stream backpressure. Sticky status and beat/frame counters are readable over the same AXI-Lite port.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width; also the TDATA width.
- C_S_AXI_ADDR_WIDTH, 5, AXI-Lite byte address width (8 word registers).
- FIFO_DEPTH, 4, FIFO entries; power of two, ≥2.
- aclk  in  1  single clock for both interfaces.
- areset  in  1  asynchronous, active-high reset.
- s_axi_awaddr/awvalid/awready, s_axi_wdata/wstrb/wvalid/wready, s_axi_bresp/bvalid/bready, s_axi_araddr/arvalid/arready, s_axi_rdata/rresp/rvalid/rready  per AXI4-Lite  AXI-Lite slave; prot inputs are present and ignored.
- m_axis_tdata  out  C_S_AXI_DATA_WIDTH  stream data.
- m_axis_tlast  out  1  end of frame.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.

## Operation
- Register map (byte offsets):
  - 0x00 DATA (W): push wdata with tlast=0.
  - 0x04 DATA_LAST (W): push wdata with tlast=1.
  - 0x08 STATUS (R): bit0 full; bit1 empty; bits[4:2] level (0..FIFO_DEPTH); bit8 overflow (sticky).
  - 0x0C CTRL (R/W): bit0 enable, reset 0; bit1 flush, self-clearing, reads 0; bit2 write-1 clears overflow, reads 0.
  - 0x10 WORD_COUNT (R): accepted stream beats.
  - 0x14 FRAME_COUNT (R): accepted beats with tlast=1.
  - Other offsets read 0; writes to them are ignored with OKAY.
- Writes:
  - awready and wready assert together, for one cycle, only when awvalid && wvalid && !bvalid.
  - wstrb is ignored for DATA and DATA_LAST, which always push the full word. CTRL honours wstrb[0].
  - A push to a full FIFO drops the word, sets overflow, and returns bresp=2'b10 (SLVERR). Every other write returns 2'b00.
- Reads:
  - arready asserts for one cycle when arvalid && !rvalid.
  - rdata and rresp=00 are registered and held with rvalid until rready.
- Stream output:
  - tvalid = enable && !empty.
  - tdata and tlast come straight from the FIFO head entry.
  - A beat pops when tvalid && tready.
  - Clearing enable while tvalid is high is allowed; the head entry stays put.
- Counters:
  - 32-bit, increment on each popped beat (FRAME_COUNT only when tlast=1).
  - Wrap 0xFFFFFFFF→0.
  - Cleared only by reset.

## Timing
- Reset values:
  - All ready/valid outputs 0; bresp, rresp, rdata 0.
  - FIFO empty, so tvalid=0; tdata and tlast are 0 while empty.
  - enable=0, overflow=0, counters 0.
- Write latency:
  - Handshake in cycle N gives bvalid=1 in N+1, held until bready.
  - A pushed word is visible at the head, and tvalid can rise, in N+1.
- Read latency: arvalid && arready in N gives rvalid in N+1. STATUS and counters are sampled in cycle N.
- Full and empty flags are evaluated at the start of the cycle. A push when full is refused even if a pop happens in the same cycle.
- Push and pop in the same cycle on a non-empty, non-full FIFO leave the level unchanged.
- Flush:
  - A CTRL write with bit1=1 empties the FIFO in N+1.
  - A pop handshake in cycle N still counts and is consumed.
- Overflow clear and a new overflow in the same write cannot coincide (one write per transaction).
- Reset asserted mid-transaction aborts any pending bvalid or rvalid immediately. Stream beats in flight are lost.

## Configuration
- L2S_COUNTERS_EN defined: WORD_COUNT and FRAME_COUNT registers are implemented as above.
- L2S_COUNTERS_EN undefined: counter logic is removed and offsets 0x10/0x14 read 0. STATUS and CTRL are unaffected.

## Structure
- Package l2s_pkg holds:
  - register offset constants;
  - STATUS and CTRL bit positions;
  - RESP_OKAY/RESP_SLVERR codes;
  - FIFO entry typedef {tlast, tdata}.
- Sub-module l2s_fifo:
  - synchronous FIFO, FIFO_DEPTH entries;
  - push/pop interface with full, empty, level and flush ports;
  - wrap-around pointers with an extra MSB for full/empty.
- Top level holds the AXI-Lite FSMs, register file and counters.

## Test plan
- Reset, then read STATUS → 0x00000002 (empty). Read CTRL → 0. tvalid=0.
- Write CTRL=1. Write DATA 0x11, 0x22, then DATA_LAST 0x33, with tready=1 → three beats 0x11, 0x22, 0x33, tlast only on 0x33. WORD_COUNT=3, FRAME_COUNT=1.
- enable=0. Push 5 words to the 4-deep FIFO → 5th bresp=SLVERR. STATUS = full | level 4 | overflow = 0x111. Write CTRL=4 → overflow cleared.
- FIFO full, tready=0. Enable, then toggle tready every other cycle → beats emitted in order, tdata held stable while tready=0.
- Load 3 words with enable=0. Write CTRL=2 (flush) → STATUS reads empty. No beats emitted after enable=1.
- Assert areset while bvalid=1 and the FIFO holds 2 words → bvalid=0 and tvalid=0 immediately. STATUS reads 0x2 after release.
